muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit.
- Consumes operands read from the register file in the execute stage and produces a result plus destination address for the writeback data/write-enable path.
- Asserts busy_o while computing so hazard logic can stall the pipeline.
- Radix-2: one partial product or quotient bit per cycle, plus a sign-fix cycle.

---
 rtl/muldiv_unit.sv | 202 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit: one product or quotient bit per cycle,
// then a sign-fix cycle. Divide-by-zero and signed overflow bypass the iteration.
module muldiv_unit #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDRESS_WIDTH = 5
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start_i,
   input  logic                     flush_i,
   input  logic [2:0]               op_i,
   input  logic [DATA_WIDTH-1:0]    src_a_i,
   input  logic [DATA_WIDTH-1:0]    src_b_i,
   input  logic [ADDRESS_WIDTH-1:0] rd_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic [DATA_WIDTH-1:0]    result_o,
   output logic [ADDRESS_WIDTH-1:0] rd_o
);

   localparam int unsigned DW = DATA_WIDTH;
   localparam int unsigned CW = $clog2(DATA_WIDTH);
   localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};
   localparam logic [CW-1:0] LAST = CW'(DW - 1);

   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_REM    = 3'b110;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIX,
      S_DONE
   } state_t;

   state_t                   state_q;
   logic [2:0]               op_q;
   logic [ADDRESS_WIDTH-1:0] rd_q;
   logic                     neg_q;
   logic [CW-1:0]            cnt_q;
   logic [DW-1:0]            a_q;
   logic [DW-1:0]            b_q;
   logic [2*DW-1:0]          acc_q;
   logic [DW-1:0]            quo_q;
   logic [DW:0]              rem_q;
   logic [DW-1:0]            res_q;
   logic                     busy_q;
   logic                     done_q;
   logic [DW-1:0]            result_q;
   logic [ADDRESS_WIDTH-1:0] rd_out_q;

   // Acceptance-time decode: operand magnitudes, result sign, fast-path detection.
   logic          a_signed;
   logic          b_signed;
   logic          a_neg;
   logic          b_neg;
   logic          neg_d;
   logic [DW-1:0] a_mag_d;
   logic [DW-1:0] b_mag_d;
   logic          div_zero;
   logic          div_ovf;
   logic [DW-1:0] fast_res_d;

   always_comb begin
      a_signed = 1'b0;
      b_signed = 1'b0;
      case (op_i)
         OP_MULH:        begin a_signed = 1'b1; b_signed = 1'b1; end
         OP_MULHSU:      a_signed = 1'b1;
         OP_DIV, OP_REM: begin a_signed = 1'b1; b_signed = 1'b1; end
         default:        ;
      endcase
      a_neg   = a_signed & src_a_i[DW-1];
      b_neg   = b_signed & src_b_i[DW-1];
      a_mag_d = a_neg ? -src_a_i : src_a_i;
      b_mag_d = b_neg ? -src_b_i : src_b_i;
      neg_d   = (op_i == OP_REM || op_i == OP_MULHSU) ? a_neg : (a_neg ^ b_neg);

      div_zero = op_i[2] && (src_b_i == '0);
      div_ovf  = (op_i == OP_DIV || op_i == OP_REM) && (src_a_i == SMIN) && (src_b_i == '1);
      fast_res_d = '0;
      if (div_zero) begin
         fast_res_d = op_i[1] ? src_a_i : '1;
      end else if (div_ovf) begin
         fast_res_d = op_i[1] ? '0 : SMIN;
      end
   end

   // Shift-add: the multiplier sits in the low half of the accumulator and is
   // consumed LSB first while the partial sum grows into the high half.
   logic [DW:0]     mul_sum;
   logic [2*DW-1:0] acc_d;
   assign mul_sum = {1'b0, acc_q[2*DW-1:DW]} + (acc_q[0] ? {1'b0, a_q} : '0);
   assign acc_d   = {mul_sum, acc_q[DW-1:1]};

   // Restoring division: one extra guard bit above the remainder register gives
   // the borrow that decides whether the trial subtraction is kept.
   logic [DW+1:0] div_diff;
   logic          div_ok;
   assign div_diff = {rem_q, quo_q[DW-1]} - {2'b00, b_q};
   assign div_ok   = ~div_diff[DW+1];

   logic [2*DW-1:0] prod_fix;
   logic [DW-1:0]   quo_fix;
   logic [DW-1:0]   rem_fix;
   logic [DW-1:0]   fix_res;
   assign prod_fix = neg_q ? -acc_q : acc_q;
   assign quo_fix  = neg_q ? -quo_q : quo_q;
   assign rem_fix  = neg_q ? -rem_q[DW-1:0] : rem_q[DW-1:0];
   assign fix_res  = op_q[2] ? (op_q[1] ? rem_fix : quo_fix)
                             : ((op_q[1:0] == 2'b00) ? prod_fix[DW-1:0] : prod_fix[2*DW-1:DW]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         rd_q     <= '0;
         neg_q    <= 1'b0;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         quo_q    <= '0;
         rem_q    <= '0;
         res_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         rd_out_q <= '0;
      end else begin
         done_q <= 1'b0;
         if (flush_i && state_q != S_IDLE) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start_i && !flush_i) begin
                     op_q   <= op_i;
                     rd_q   <= rd_i;
                     neg_q  <= neg_d;
                     cnt_q  <= '0;
                     a_q    <= a_mag_d;
                     b_q    <= b_mag_d;
                     acc_q  <= {{DW{1'b0}}, b_mag_d};
                     quo_q  <= a_mag_d;
                     rem_q  <= '0;
                     busy_q <= 1'b1;
                     if (div_zero || div_ovf) begin
                        res_q   <= fast_res_d;
                        state_q <= S_DONE;
                     end else begin
                        state_q <= op_i[2] ? S_DIV : S_MUL;
                     end
                  end
               end
               S_MUL: begin
                  acc_q <= acc_d;
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == LAST) begin
                     state_q <= S_FIX;
                  end
               end
               S_DIV: begin
                  rem_q <= div_ok ? div_diff[DW:0] : {rem_q[DW-1:0], quo_q[DW-1]};
                  quo_q <= {quo_q[DW-2:0], div_ok};
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == LAST) begin
                     state_q <= S_FIX;
                  end
               end
               S_FIX: begin
                  res_q   <= fix_res;
                  state_q <= S_DONE;
               end
               S_DONE: begin
                  result_q <= res_q;
                  rd_out_q <= rd_q;
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
                  cnt_q    <= '0;
                  state_q  <= S_IDLE;
               end
               default: begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign result_o = result_q;
   assign rd_o     = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model plus cycle-count timing model,
// compared against the DUT every cycle, with directed vectors pinned to literals.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_i = 1'b0;
   logic        flush_i = 1'b0;
   logic [2:0]  op_i = '0;
   logic [31:0] src_a_i = '0;
   logic [31:0] src_b_i = '0;
   logic [4:0]  rd_i = '0;
   logic        busy_o;
   logic        done_o;
   logic [31:0] result_o;
   logic [4:0]  rd_o;

   int checks = 0;
   int errors = 0;

   muldiv_unit #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_i  (start_i),
      .flush_i  (flush_i),
      .op_i     (op_i),
      .src_a_i  (src_a_i),
      .src_b_i  (src_b_i),
      .rd_i     (rd_i),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .result_o (result_o),
      .rd_o     (rd_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
      end
   endtask

   // RV32M semantics straight from the instruction definitions.
   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, sp;
      logic [63:0] ua, ub, up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         3'd0: begin up = ua * ub; return up[31:0]; end
         3'd1: begin sp = sa * sb; up = sp; return up[63:32]; end
         3'd2: begin sp = sa * longint'(ua); up = sp; return up[63:32]; end
         3'd3: begin up = ua * ub; return up[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            sp = sa / sb; up = sp; return up[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            return a / b;
         end
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            sp = sa % sb; up = sp; return up[31:0];
         end
         default: begin
            if (b == 0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (!op[2]) return 1'b0;
      if (b == 0) return 1'b1;
      return (op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
   endfunction

   // Timing model: an accepted op completes a fixed number of edges later.
   int          remaining = 0;
   logic        exp_busy = 1'b0;
   logic        exp_done = 1'b0;
   logic [31:0] exp_res = '0;
   logic [4:0]  exp_rd = '0;
   logic [31:0] pend_res = '0;
   logic [4:0]  pend_rd = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         remaining = 0;
         exp_busy  = 1'b0;
         exp_done  = 1'b0;
         exp_res   = '0;
         exp_rd    = '0;
      end else begin
         exp_done = 1'b0;
         if (remaining > 0) begin
            if (flush_i) begin
               remaining = 0;
               exp_busy  = 1'b0;
            end else begin
               remaining--;
               if (remaining == 0) begin
                  exp_done = 1'b1;
                  exp_busy = 1'b0;
                  exp_res  = pend_res;
                  exp_rd   = pend_rd;
               end
            end
         end else if (start_i && !flush_i) begin
            pend_res  = model(op_i, src_a_i, src_b_i);
            pend_rd   = rd_i;
            remaining = is_fast(op_i, src_a_i, src_b_i) ? 1 : 34;
            exp_busy  = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      chk("busy", busy_o, exp_busy);
      chk("done", done_o, exp_done);
      chk("result", result_o, exp_res);
      chk("rd", rd_o, exp_rd);
   end

   task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      op_i    = op;
      src_a_i = a;
      src_b_i = b;
      rd_i    = rd;
   endtask

   // Pulses start for one cycle, scrambles operands afterwards, and measures the
   // cycle in which done_o appears (cycle n = cycle following edge n-1... counted from acceptance edge 0).
   task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] lit, input int lat);
      int n;
      bit got;
      @(negedge clk);
      drive(op, a, b, rd);
      start_i = 1'b1;
      chk({"model_", nm}, model(op, a, b), lit);
      got = 1'b0;
      n = 0;
      while (!got && n < 100) begin
         @(negedge clk);
         n++;
         start_i = 1'b0;
         src_a_i = $urandom;
         src_b_i = $urandom;
         rd_i    = 5'($urandom);
         if (done_o) begin
            got = 1'b1;
            chk({"res_", nm}, result_o, lit);
            chk({"rdo_", nm}, rd_o, rd);
            chk({"lat_", nm}, n, lat);
         end
      end
      if (!got) chk({"timeout_", nm}, 0, 1);
   endtask

   initial begin
      int dones;
      int n;
      bit got;
      logic [31:0] held;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_result", result_o, 0);
      chk("rst_rd", rd_o, 0);
      #2 rst_n = 1'b1;

      run_op("mul",    3'd0, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 35);
      run_op("mulh",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'h0000_0000, 35);
      run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFF, 35);
      run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 35);
      run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFD, 35);
      run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFF, 35);
      run_op("divu",   3'd5, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'h7FFF_FFFC, 35);
      run_op("remu",   3'd7, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'd1,         35);
      run_op("mulh_s", 3'd1, 32'h8000_0000, 32'd3,         5'd11, 32'hFFFF_FFFE, 35);
      run_op("rem_b",  3'd6, 32'd100,       32'hFFFF_FFF9, 5'd0,  32'd2,         35);
      run_op("divu_z", 3'd5, 32'd123,       32'd0,         5'd12, 32'hFFFF_FFFF, 2);
      run_op("rem_z",  3'd6, 32'd123,       32'd0,         5'd13, 32'd123,       2);
      run_op("div_ov", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 2);
      run_op("rem_ov", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0,         2);

      // Flush at cycle 10 of a DIV.
      held = result_o;
      @(negedge clk);
      drive(3'd4, 32'd1000, 32'd7, 5'd20);
      start_i = 1'b1;
      dones = 0;
      for (int i = 1; i <= 50; i++) begin
         @(negedge clk);
         start_i = 1'b0;
         flush_i = (i == 10);
         if (i == 11) chk("flush_busy", busy_o, 0);
         if (done_o) dones++;
      end
      chk("flush_nodone", dones, 0);
      chk("flush_hold", result_o, held);

      // A second start while busy is dropped.
      @(negedge clk);
      drive(3'd5, 32'd100, 32'd7, 5'd4);
      start_i = 1'b1;
      dones = 0;
      for (int i = 1; i <= 80; i++) begin
         @(negedge clk);
         start_i = (i == 5);
         if (i == 5) drive(3'd0, 32'd3, 32'd4, 5'd6);
         if (done_o) begin
            dones++;
            chk("ign_lat", i, 35);
            chk("ign_res", result_o, 14);
            chk("ign_rd", rd_o, 4);
         end
      end
      chk("ign_count", dones, 1);

      // Asynchronous reset in the middle of a MUL.
      @(negedge clk);
      drive(3'd0, 32'd1234, 32'd5678, 5'd21);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (19) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", busy_o, 0);
      chk("arst_done", done_o, 0);
      chk("arst_result", result_o, 0);
      chk("arst_rd", rd_o, 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done_o) dones++;
      end
      chk("arst_nodone", dones, 0);
      run_op("mul34", 3'd0, 32'd3, 32'd4, 5'd22, 32'd12, 35);

      // start_i held: next op accepted in the idle cycle that shows done_o.
      @(negedge clk);
      drive(3'd0, 32'd5, 32'd6, 5'd3);
      start_i = 1'b1;
      dones = 0;
      n = 0;
      got = 1'b0;
      while (!got && n < 120) begin
         @(negedge clk);
         n++;
         if (done_o) begin
            dones++;
            if (dones == 1) begin
               chk("b2b_lat1", n, 35);
               chk("b2b_res1", result_o, 30);
               drive(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);
            end else begin
               got = 1'b1;
               chk("b2b_lat2", n, 70);
               chk("b2b_res2", result_o, 32'hFFFF_FFFE);
               chk("b2b_rd2", rd_o, 9);
            end
         end
      end
      start_i = 1'b0;
      if (!got) chk("b2b_timeout", 0, 1);
      repeat (40) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
